// File: rtl/execute_multiply_iter.sv
// Iterative MUL/IMUL/AAD multiplier: magnitude shift-add at BPC bits per cycle,
// followed by a sign fix-up cycle and a one-cycle DONE handshake.
//
// state | meaning
// IDLE  | waiting for mult_cmd; latches operands, size and kind on start
// RUN   | retires BPC multiplier bits per cycle into the magnitude accumulator
// FIX   | applies the sign and writes mult_result
// DONE  | mult_done pulse, mult_busy low for one cycle
module execute_multiply_iter #(
    parameter int WIDTH     = 32,
    parameter int BPC       = 4,
    parameter int EARLY_OUT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exe_reset,
    input  logic [1:0]           mult_cmd,
    input  logic                 exe_is_8bit,
    input  logic                 exe_operand_16bit,
    input  logic [WIDTH-1:0]     src,
    input  logic [WIDTH-1:0]     dst,
    output logic [2*WIDTH+1:0]   mult_result,
    output logic                 mult_busy,
    output logic                 mult_done,
    output logic                 exe_mult_overflow
);

    localparam int RW = 2*WIDTH + 2;
    localparam int PW = 2*WIDTH;
    localparam int CW = $clog2(32/BPC + 1);
    localparam int SW = 6;

    localparam logic [1:0] SZ8  = 2'd0;
    localparam logic [1:0] SZ16 = 2'd1;
    localparam logic [1:0] SZ32 = 2'd2;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_IMUL = 2'd2;
    localparam logic [1:0] CMD_AAD  = 2'd3;

    localparam logic [CW-1:0] N8  = CW'(8/BPC);
    localparam logic [CW-1:0] N16 = CW'(16/BPC);
    localparam logic [CW-1:0] N32 = CW'(32/BPC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       sz_q;
    logic             sgn_q;
    logic             neg_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc_q;
    logic [SW-1:0]    shift_q;
    logic [CW-1:0]    cnt_q;

    // Keeps the low S bits of v and fills the rest with the (optional) sign.
    function automatic logic [WIDTH-1:0] size_ext(input logic [WIDTH-1:0] v,
                                                  input logic [1:0] sz,
                                                  input logic sg);
        logic [WIDTH-1:0] msk;
        logic             sbit;
        case (sz)
            SZ8:     begin msk = WIDTH'(8'hFF);          sbit = v[7];  end
            SZ16:    begin msk = WIDTH'(16'hFFFF);       sbit = v[15]; end
            default: begin msk = WIDTH'(32'hFFFF_FFFF);  sbit = v[31]; end
        endcase
        return (v & msk) | ((sg & sbit) ? ~msk : '0);
    endfunction

    // Start-cycle operand decode
    logic             start;
    logic [1:0]       sz_start;
    logic             sgn_start;
    logic [WIDTH-1:0] a_raw, b_raw, a_ext, b_ext;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [CW-1:0]    n_start;

    always_comb begin
        start     = (state == ST_IDLE) && (mult_cmd != CMD_NONE) && !exe_reset;
        sz_start  = SZ32;
        if (mult_cmd == CMD_AAD || exe_is_8bit)
            sz_start = SZ8;
        else if (exe_operand_16bit)
            sz_start = SZ16;
        sgn_start = (mult_cmd == CMD_IMUL);
        a_raw     = src;
        b_raw     = dst;
        if (mult_cmd == CMD_AAD) begin
            a_raw = {{(WIDTH-8){1'b0}}, src[7:0]};
            b_raw = {{(WIDTH-8){1'b0}}, dst[15:8]};
        end
        a_ext = size_ext(a_raw, sz_start, sgn_start);
        b_ext = size_ext(b_raw, sz_start, sgn_start);
        neg_a = sgn_start & a_ext[WIDTH-1];
        neg_b = sgn_start & b_ext[WIDTH-1];
        // -0x80000000 sign-extended is 2^31, which still fits unsigned.
        a_mag = neg_a ? -a_ext : a_ext;
        b_mag = neg_b ? -b_ext : b_ext;
        case (sz_start)
            SZ8:     n_start = N8;
            SZ16:    n_start = N16;
            default: n_start = N32;
        endcase
    end

    // One RUN step
    logic [WIDTH+BPC-1:0] pp;
    logic [PW-1:0]        pp_sh;
    logic [WIDTH-1:0]     b_nxt;
    logic                 run_last;

    always_comb begin
        pp       = {{BPC{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[BPC-1:0]};
        pp_sh    = {{(PW-WIDTH-BPC){1'b0}}, pp} << shift_q;
        b_nxt    = b_q >> BPC;
        run_last = (cnt_q == CW'(1)) || ((EARLY_OUT != 0) && (b_nxt == '0));
    end

    logic [RW-1:0] fix_val;
    assign fix_val = neg_q ? -{2'b00, acc_q} : {2'b00, acc_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mult_cmd != CMD_NONE) state_nxt = ST_RUN;
            ST_RUN:  if (run_last) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (exe_reset)
            state_nxt = ST_IDLE;
    end

    always_comb begin
        mult_busy = (state != ST_DONE);
        mult_done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sz_q    <= SZ32;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            sz_q    <= sz_start;
            sgn_q   <= sgn_start;
            neg_q   <= neg_a ^ neg_b;
            a_q     <= a_mag;
            b_q     <= b_mag;
            acc_q   <= '0;
            shift_q <= '0;
            cnt_q   <= n_start;
        end else if (state == ST_RUN && !exe_reset) begin
            acc_q   <= acc_q + pp_sh;
            b_q     <= b_nxt;
            shift_q <= shift_q + SW'(BPC);
            cnt_q   <= cnt_q - CW'(1);
        end
    end

    // An aborted FIX must leave the previous result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mult_result <= '0;
        else if (state == ST_FIX && !exe_reset)
            mult_result <= fix_val;
    end

    logic [RW-1:0] res_msk;
    logic          res_sbit;

    always_comb begin
        case (sz_q)
            SZ8:     begin res_msk = RW'(8'hFF);         res_sbit = mult_result[7];  end
            SZ16:    begin res_msk = RW'(16'hFFFF);      res_sbit = mult_result[15]; end
            default: begin res_msk = RW'(32'hFFFF_FFFF); res_sbit = mult_result[31]; end
        endcase
        exe_mult_overflow = (mult_result & ~res_msk) !=
                            ((sgn_q & res_sbit) ? ~res_msk : '0);
    end

endmodule

// File: tb/tb_execute_multiply_iter.sv
// Directed bench for execute_multiply_iter: three instances (BPC=4 without and
// with early-out, BPC=1 without early-out) share one stimulus stream.
module tb_execute_multiply_iter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              exe_reset = 1'b0;
    logic [1:0]        mult_cmd = 2'd0;
    logic              exe_is_8bit = 1'b0;
    logic              exe_operand_16bit = 1'b0;
    logic [31:0]       src = '0;
    logic [31:0]       dst = '0;
    logic [2:0][65:0]  res_v;
    logic [2:0]        busy_v, done_v, ovf_v;

    always #5 clk = ~clk;

    execute_multiply_iter #(.WIDTH(32), .BPC(4), .EARLY_OUT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .exe_reset(exe_reset), .mult_cmd(mult_cmd),
        .exe_is_8bit(exe_is_8bit), .exe_operand_16bit(exe_operand_16bit),
        .src(src), .dst(dst), .mult_result(res_v[0]), .mult_busy(busy_v[0]),
        .mult_done(done_v[0]), .exe_mult_overflow(ovf_v[0]));

    execute_multiply_iter #(.WIDTH(32), .BPC(4), .EARLY_OUT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .exe_reset(exe_reset), .mult_cmd(mult_cmd),
        .exe_is_8bit(exe_is_8bit), .exe_operand_16bit(exe_operand_16bit),
        .src(src), .dst(dst), .mult_result(res_v[1]), .mult_busy(busy_v[1]),
        .mult_done(done_v[1]), .exe_mult_overflow(ovf_v[1]));

    execute_multiply_iter #(.WIDTH(32), .BPC(1), .EARLY_OUT(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .exe_reset(exe_reset), .mult_cmd(mult_cmd),
        .exe_is_8bit(exe_is_8bit), .exe_operand_16bit(exe_operand_16bit),
        .src(src), .dst(dst), .mult_result(res_v[2]), .mult_busy(busy_v[2]),
        .mult_done(done_v[2]), .exe_mult_overflow(ovf_v[2]));

    typedef struct {
        logic [1:0]  cmd;
        logic        i8;
        logic        i16;
        logic [31:0] s;
        logic [31:0] d;
        logic [65:0] r;
        logic        ovf;
        int          lat_b;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          got_lat[3];
    logic [65:0] got_res[3];
    logic        got_ovf[3];

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts one operation (cycle 0) and watches every instance for up to 40 cycles.
    task automatic run_op(input logic [1:0] cmd, input logic i8, input logic i16,
                          input logic [31:0] s, input logic [31:0] d);
        @(negedge clk);
        mult_cmd = cmd; exe_is_8bit = i8; exe_operand_16bit = i16; src = s; dst = d;
        for (int i = 0; i < 3; i++) begin
            got_lat[i] = -1; got_res[i] = '0; got_ovf[i] = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mult_cmd = 2'd0; exe_is_8bit = ~i8; exe_operand_16bit = ~i16;
                src = ~s; dst = 32'h0;
            end
            for (int i = 0; i < 3; i++) begin
                if (got_lat[i] < 0 && done_v[i]) begin
                    got_lat[i] = k; got_res[i] = res_v[i]; got_ovf[i] = ovf_v[i];
                end
            end
        end
    endtask

    initial begin
        int          sz;
        int          exp_lat[3];
        int          dones;
        logic [65:0] prev;

        vecs[0]  = '{2'd1, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_00FF, 66'hFE01, 1'b1, 4};
        vecs[1]  = '{2'd2, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0002, 66'h3_FFFF_FFFF_FFFF_FFFE, 1'b0, 3};
        vecs[2]  = '{2'd2, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_4000, 66'h3_FFFF_FFFF_FFFF_C000, 1'b0, 6};
        vecs[3]  = '{2'd2, 1'b0, 1'b1, 32'h0000_7FFF, 32'h0000_0002, 66'hFFFE, 1'b1, 3};
        vecs[4]  = '{2'd2, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 66'h4000_0000_0000_0000, 1'b1, 10};
        vecs[5]  = '{2'd3, 1'b0, 1'b0, 32'h1234_560A, 32'hABCD_0305, 66'h1E, 1'b0, 3};
        vecs[6]  = '{2'd1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0001, 66'h1234_5678, 1'b0, 3};
        vecs[7]  = '{2'd1, 1'b0, 1'b1, 32'hDEAD_1234, 32'hBEEF_0010, 66'h1_2340, 1'b1, 4};
        vecs[8]  = '{2'd2, 1'b1, 1'b0, 32'h1234_5680, 32'hABCD_EFFF, 66'h80, 1'b1, 3};
        vecs[9]  = '{2'd2, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 66'h3_FFFF_FFFF_FFFF_FFEB, 1'b0, 3};
        vecs[10] = '{2'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 66'hFFFF_FFFE_0000_0001, 1'b1, 10};
        vecs[11] = '{2'd1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000, 66'h0, 1'b0, 3};
        vecs[12] = '{2'd2, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_FFFB, 66'h3_FFFF_FFFF_FFFF_FFF1, 1'b0, 3};

        // Reset values while rst_n is held low
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_result_%0d", i), res_v[i], 66'h0);
            chk($sformatf("rst_busy_%0d", i), 66'(busy_v[i]), 66'h1);
            chk($sformatf("rst_done_%0d", i), 66'(done_v[i]), 66'h0);
            chk($sformatf("rst_ovf_%0d", i), 66'(ovf_v[i]), 66'h0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int n = 0; n < NV; n++) begin
            sz = (vecs[n].cmd == 2'd3 || vecs[n].i8) ? 8 : (vecs[n].i16 ? 16 : 32);
            exp_lat[0] = sz/4 + 2;
            exp_lat[1] = vecs[n].lat_b;
            exp_lat[2] = sz + 2;
            run_op(vecs[n].cmd, vecs[n].i8, vecs[n].i16, vecs[n].s, vecs[n].d);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("v%0d_lat_%0d", n, i), 66'(got_lat[i]), 66'(exp_lat[i]));
                chk($sformatf("v%0d_res_%0d", n, i), got_res[i], vecs[n].r);
                chk($sformatf("v%0d_ovf_%0d", n, i), 66'(got_ovf[i]), 66'(vecs[n].ovf));
            end
        end

        // Flush in cycle 2 of a 32-bit MUL, then flush together with a command in IDLE
        prev = vecs[NV-1].r;
        @(negedge clk);
        mult_cmd = 2'd1; exe_is_8bit = 1'b0; exe_operand_16bit = 1'b0;
        src = 32'h1111_1111; dst = 32'hFFFF_FFFF;
        @(negedge clk);
        mult_cmd = 2'd0;
        @(negedge clk);
        exe_reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_busy_%0d", i), 66'(busy_v[i]), 66'h1);
            chk($sformatf("abort_done_%0d", i), 66'(done_v[i]), 66'h0);
            chk($sformatf("abort_res_%0d", i), res_v[i], prev);
        end
        mult_cmd = 2'd1;
        dones = 0;
        @(negedge clk);
        exe_reset = 1'b0; mult_cmd = 2'd0;
        for (int k = 0; k < 40; k++) begin
            dones += $countones(done_v);
            @(negedge clk);
        end
        chk("abort_no_done", 66'(dones), 66'h0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("abort_res_hold_%0d", i), res_v[i], prev);

        run_op(2'd1, 1'b0, 1'b0, 32'd3, 32'd5);
        chk("after_abort_lat_a", 66'(got_lat[0]), 66'd10);
        chk("after_abort_lat_b", 66'(got_lat[1]), 66'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("after_abort_res_%0d", i), got_res[i], 66'hF);
            chk($sformatf("after_abort_ovf_%0d", i), 66'(got_ovf[i]), 66'h0);
        end

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        mult_cmd = 2'd1; src = 32'd7; dst = 32'hFFFF_0009;
        @(negedge clk);
        mult_cmd = 2'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_rst_res_%0d", i), res_v[i], 66'h0);
            chk($sformatf("async_rst_busy_%0d", i), 66'(busy_v[i]), 66'h1);
            chk($sformatf("async_rst_done_%0d", i), 66'(done_v[i]), 66'h0);
            chk($sformatf("async_rst_ovf_%0d", i), 66'(ovf_v[i]), 66'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
